// File: rtl/seg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_ctrl_pkg
// Shared constants for the 7-seg message sequencer: display codes understood by
// the board's BCD decoders (0-9 are plain digits) and the sequencer state type.
// -----------------------------------------------------------------------------
package seg_ctrl_pkg;

    localparam logic [3:0] SEG_OFF  = 4'hA;
    localparam logic [3:0] SEG_DASH = 4'hB;
    localparam logic [3:0] SEG_H    = 4'hC;
    localparam logic [3:0] SEG_L    = 4'hD;
    localparam logic [3:0] SEG_E    = 4'hE;
    localparam logic [3:0] SEG_P    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STATIC = 2'd2,
        ST_SCROLL = 2'd3
    } seg_state_e;

endpackage

// File: rtl/seg_tick_gen.sv
// -----------------------------------------------------------------------------
// seg_tick_gen
// Prescaler producing a one-cycle tick every CLK_DIV clocks. Used for both the
// scroll step and the blink phase.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  force the count to zero (wins over hold)
//   hold  in  freeze the count; no tick while held
//   tick  out high while the count sits at CLK_DIV-1 and is about to wrap
// -----------------------------------------------------------------------------
module seg_tick_gen #(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = !clr && !hold && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scroll_ctrl
// Message sequencer for NUM_DIGITS BCD 7-seg decoders. A nibble-coded message is
// taken over a load/ready handshake; it is shown static if it fits the display,
// otherwise it scrolls left one position per tick with one blank gap before wrap.
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   synchronous active-high reset
//   load     in   message valid; accepted when load && ready
//   ready    out  block can accept a message (low only in LOAD)
//   msg      in   char i = msg[4i+3:4i], char 0 leftmost
//   msg_len  in   chars used, clamped to MSG_LEN
//   hold     in   freeze scroll position, prescaler (and blink phase)
//   blink    in   (SEG_BLINK_EN only) blink the enabled digits each tick
//   bcd      out  digit d = bcd[4d+3:4d], digit 0 leftmost, registered
//   en       out  per-digit decoder enable
// Build option: define SEG_BLINK_EN to add the blink port and phase register.
//
// state  | meaning
// IDLE   | nothing shown, all digits off
// LOAD   | message captured, old frame still shown, ready low
// STATIC | message fits the display, frame fixed
// SCROLL | message longer than display, frame shifts on each tick
// -----------------------------------------------------------------------------
module seg_scroll_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned CLK_DIV    = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    output logic                          ready,
    input  logic [4*MSG_LEN-1:0]          msg,
    input  logic [$clog2(MSG_LEN+1)-1:0]  msg_len,
    input  logic                          hold,
`ifdef SEG_BLINK_EN
    input  logic                          blink,
`endif
    output logic [4*NUM_DIGITS-1:0]       bcd,
    output logic [NUM_DIGITS-1:0]         en
);

    localparam int unsigned LW = $clog2(MSG_LEN + 1);

    seg_state_e              state_q, state_d;
    logic [4*MSG_LEN-1:0]    msg_q, msg_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           ptr_q, ptr_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    accept;
    logic                    tick;
    logic [LW-1:0]           len_clamp;

    // Window of the message starting at char ptr; position len is the blank gap.
    // ptr + d never reaches 2*(len+1) because NUM_DIGITS < len+1, so one
    // subtraction implements the modulo.
    function automatic logic [4*NUM_DIGITS-1:0] scroll_frame(
        input logic [4*MSG_LEN-1:0] m,
        input logic [LW-1:0]        len,
        input logic [LW-1:0]        ptr
    );
        logic [4*NUM_DIGITS-1:0] f;
        int idx;
        f = {NUM_DIGITS{SEG_OFF}};
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            idx = int'(ptr) + d;
            if (idx > int'(len)) begin
                idx = idx - (int'(len) + 1);
            end
            if (idx != int'(len)) begin
                f[4*d +: 4] = m[4*idx +: 4];
            end
        end
        return f;
    endfunction

    function automatic logic [4*NUM_DIGITS-1:0] static_frame(
        input logic [4*MSG_LEN-1:0] m,
        input logic [LW-1:0]        len
    );
        logic [4*NUM_DIGITS-1:0] f;
        f = {NUM_DIGITS{SEG_OFF}};
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (d < int'(len)) begin
                f[4*d +: 4] = m[4*d +: 4];
            end
        end
        return f;
    endfunction

    assign ready     = (state_q != ST_LOAD);
    assign accept    = load && ready;
    assign len_clamp = (int'(msg_len) > int'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;

    // Prescaler held at zero through LOAD so the first frame lasts a full CLK_DIV.
    seg_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept || (state_q == ST_LOAD)),
        .hold (hold),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        bcd_d   = bcd_q;
        en_d    = en_q;
        if (accept) begin
            state_d = ST_LOAD;
            msg_d   = msg;
            len_d   = len_clamp;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (len_q == '0) begin
                        state_d = ST_IDLE;
                        bcd_d   = {NUM_DIGITS{SEG_OFF}};
                        en_d    = '0;
                    end else if (int'(len_q) <= int'(NUM_DIGITS)) begin
                        state_d = ST_STATIC;
                        bcd_d   = static_frame(msg_q, len_q);
                        en_d    = '1;
                    end else begin
                        state_d = ST_SCROLL;
                        bcd_d   = scroll_frame(msg_q, len_q, '0);
                        en_d    = '1;
                    end
                end
                ST_SCROLL: begin
                    if (tick) begin
                        ptr_d = (ptr_q == len_q) ? '0 : ptr_q + 1'b1;
                        bcd_d = scroll_frame(msg_q, len_q, ptr_d);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            ptr_q   <= '0;
            bcd_q   <= {NUM_DIGITS{SEG_OFF}};
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            bcd_q   <= bcd_d;
            en_q    <= en_d;
        end
    end

    assign bcd = bcd_q;

`ifdef SEG_BLINK_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (accept || !blink) begin
            phase_d = 1'b1;
        end else if (tick) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign en = en_q & {NUM_DIGITS{phase_q}};
`else
    assign en = en_q;
`endif

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
module tb_seg_scroll_ctrl;

    localparam int ND  = 4;
    localparam int ML  = 8;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        ready;
    logic [31:0] msg = '0;
    logic [3:0]  msg_len = '0;
    logic        hold = 1'b0;
    logic        blink = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  en;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: message contents plus number of un-held clock edges
    // since the new frame appeared. Scroll position follows from that count.
    logic [3:0] m_chars [ML];
    int m_len    = 0;
    int m_mode   = 0;   // 0 blank, 1 static, 2 scroll
    int m_active = 0;
    bit m_blink  = 1'b0;

    seg_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .CLK_DIV    (DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .ready   (ready),
        .msg     (msg),
        .msg_len (msg_len),
        .hold    (hold),
`ifdef SEG_BLINK_EN
        .blink   (blink),
`endif
        .bcd     (bcd),
        .en      (en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_frame();
        logic [15:0] f;
        int ptr;
        int idx;
        f = 16'hAAAA;
        if (m_mode == 1) begin
            for (int d = 0; d < ND; d++) begin
                if (d < m_len) f[4*d +: 4] = m_chars[d];
            end
        end else if (m_mode == 2) begin
            ptr = (m_active / DIV) % (m_len + 1);
            for (int d = 0; d < ND; d++) begin
                idx = (ptr + d) % (m_len + 1);
                if (idx != m_len) f[4*d +: 4] = m_chars[idx];
            end
        end
        return f;
    endfunction

    function automatic logic [3:0] exp_en(input bit phase_forced);
        logic [3:0] e;
        e = (m_mode == 0) ? 4'h0 : 4'hF;
`ifdef SEG_BLINK_EN
        if (m_blink && !phase_forced && ((m_active / DIV) % 2 == 1)) e = 4'h0;
`endif
        return e;
    endfunction

    task automatic do_load(input logic [31:0] m, input int raw_len);
        logic [15:0] old_f;
        logic [3:0]  old_en;
        old_f  = exp_frame();
        old_en = exp_en(1'b1);
        msg     = m;
        msg_len = 4'(raw_len);
        load    = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ready_low: got %b want 0", ready);
        end
        n_checks++;
        if (bcd !== old_f || en !== old_en) begin
            n_fail++;
            $display("FAIL load_frame_kept: got bcd=%h en=%h want bcd=%h en=%h", bcd, en, old_f, old_en);
        end
        m_len = (raw_len > ML) ? ML : raw_len;
        for (int i = 0; i < ML; i++) m_chars[i] = m[4*i +: 4];
        m_mode   = (m_len == 0) ? 0 : (m_len <= ND) ? 1 : 2;
        m_active = 0;
        step();
        n_checks++;
        if (ready !== 1'b1 || bcd !== exp_frame() || en !== exp_en(1'b0)) begin
            n_fail++;
            $display("FAIL load_first_frame: got ready=%b bcd=%h en=%h want ready=1 bcd=%h en=%h",
                     ready, bcd, en, exp_frame(), exp_en(1'b0));
        end
    endtask

    // hold_mode: 0 released, 1 held, 2 random
    task automatic run_cycles(input int n, input int hold_mode, input string tag);
        for (int i = 0; i < n; i++) begin
            hold = (hold_mode == 1) ? 1'b1 :
                   (hold_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            step();
            if (!hold) m_active++;
            n_checks++;
            if (bcd !== exp_frame() || en !== exp_en(1'b0) || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got bcd=%h en=%h ready=%b want bcd=%h en=%h ready=1",
                         tag, i, bcd, en, ready, exp_frame(), exp_en(1'b0));
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_mode = 0;
        m_active = 0;
        n_checks++;
        if (bcd !== 16'hAAAA || en !== 4'h0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got bcd=%h en=%h ready=%b want bcd=aaaa en=0 ready=1", bcd, en, ready);
        end
    endtask

    task automatic test_help_static();
        do_load(32'h0000_FDEC, 4);
        n_checks++;
        if (bcd !== 16'hFDEC || en !== 4'hF) begin
            n_fail++;
            $display("FAIL help_frame: got bcd=%h en=%h want bcd=fdec en=f", bcd, en);
        end
        run_cycles(40, 2, "help_static");
    endtask

    task automatic test_short();
        do_load(32'h0000_0021, 2);
        n_checks++;
        if (bcd !== 16'hAA21 || en !== 4'hF) begin
            n_fail++;
            $display("FAIL short_len2: got bcd=%h en=%h want bcd=aa21 en=f", bcd, en);
        end
        run_cycles(6, 0, "short_len2");
        do_load(32'h1234_5678, 0);
        n_checks++;
        if (bcd !== 16'hAAAA || en !== 4'h0) begin
            n_fail++;
            $display("FAIL short_len0: got bcd=%h en=%h want bcd=aaaa en=0", bcd, en);
        end
        run_cycles(6, 0, "short_len0");
        do_load($urandom(), 15);
        run_cycles(40, 0, "clamp_len15");
    endtask

    task automatic test_scroll_directed();
        do_load(32'h0065_4321, 6);
        n_checks++;
        if (bcd !== 16'h4321) begin
            n_fail++;
            $display("FAIL scroll_first: got %h want 4321", bcd);
        end
        run_cycles(4, 0, "scroll_dir_a");
        n_checks++;
        if (bcd !== 16'h5432) begin
            n_fail++;
            $display("FAIL scroll_second: got %h want 5432", bcd);
        end
        run_cycles(8, 0, "scroll_dir_b");
        n_checks++;
        if (bcd !== 16'hA654) begin
            n_fail++;
            $display("FAIL scroll_gap: got %h want a654", bcd);
        end
        run_cycles(12, 0, "scroll_dir_c");
        n_checks++;
        if (bcd !== 16'h321A) begin
            n_fail++;
            $display("FAIL scroll_wrap_gap: got %h want 321a", bcd);
        end
        run_cycles(4, 0, "scroll_dir_d");
        n_checks++;
        if (bcd !== 16'h4321) begin
            n_fail++;
            $display("FAIL scroll_full_cycle: got %h want 4321", bcd);
        end
    endtask

    task automatic test_hold();
        run_cycles(6, 0, "hold_pre");
        run_cycles(10, 1, "hold_frozen");
        run_cycles(12, 0, "hold_release");
    endtask

    task automatic test_scroll_random();
        for (int k = 0; k < 6; k++) begin
            do_load({$urandom()}, $urandom_range(ND + 1, ML));
            run_cycles(70, 2, "scroll_random");
        end
    endtask

    task automatic test_load_on_tick();
        do_load(32'h8765_4321, 8);
        run_cycles(5, 0, "tick_align");
        while ((m_active % DIV) != DIV - 1) run_cycles(1, 0, "tick_align");
        do_load(32'h0000_FDEC, 4);
        n_checks++;
        if (bcd !== 16'hFDEC) begin
            n_fail++;
            $display("FAIL load_on_tick: got %h want fdec", bcd);
        end
        run_cycles(8, 0, "after_tick_load");
    endtask

    task automatic test_load_with_hold();
        do_load(32'h0076_5432, 7);
        run_cycles(9, 0, "lh_pre");
        hold = 1'b1;
        do_load(32'h0009_8765, 5);
        run_cycles(10, 1, "lh_held");
        run_cycles(30, 2, "lh_after");
    endtask

    task automatic test_rst_mid();
        do_load(32'h0054_3210, 6);
        run_cycles(7, 0, "rst_pre");
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_mode = 0;
        m_active = 0;
        n_checks++;
        if (bcd !== 16'hAAAA || en !== 4'h0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: got bcd=%h en=%h ready=%b want bcd=aaaa en=0 ready=1", bcd, en, ready);
        end
        run_cycles(10, 0, "rst_post");
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        blink   = 1'b1;
        m_blink = 1'b1;
        do_load(32'h0000_FDEC, 4);
        run_cycles(4, 0, "blink_a");
        n_checks++;
        if (en !== 4'h0) begin
            n_fail++;
            $display("FAIL blink_off_phase: got %h want 0", en);
        end
        run_cycles(12, 2, "blink_b");
        blink   = 1'b0;
        m_blink = 1'b0;
        run_cycles(6, 0, "blink_release");
    endtask
`endif

    initial begin
        test_reset();
        test_help_static();
        test_short();
        test_scroll_directed();
        test_hold();
        test_scroll_random();
        test_load_on_tick();
        test_load_with_hold();
        test_rst_mid();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
